// File: rtl/scanline_fetch_arbiter.sv
// Framebuffer port arbiter: once-per-line prefetch of the next visible line into a
// double-banked line buffer at top priority, remaining bandwidth shared round-robin by two clients.
module scanline_fetch_arbiter #(
  parameter int V_DISPLAY      = 480,
  parameter int V_TOTAL        = 525,
  parameter int WORDS_PER_LINE = 40,
  parameter int FB_BASE        = 0,
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16
) (
  input  logic              aClock,
  input  logic              aReset,
  input  logic [9:0]        aX,
  input  logic [9:0]        aY,
  input  logic              aReq0,
  input  logic              aReq1,
  input  logic              aWe0,
  input  logic              aWe1,
  input  logic [ADDR_W-1:0] aAddr0,
  input  logic [ADDR_W-1:0] aAddr1,
  input  logic [DATA_W-1:0] aWData0,
  input  logic [DATA_W-1:0] aWData1,
  output logic              anOutAck0,
  output logic              anOutAck1,
  output logic [DATA_W-1:0] anOutRData,
  output logic              anOutMemReq,
  output logic              anOutMemWe,
  output logic [ADDR_W-1:0] anOutMemAddr,
  output logic [DATA_W-1:0] anOutMemWData,
  input  logic              aMemReady,
  input  logic [DATA_W-1:0] aMemRData,
  output logic              anOutLbWe,
  output logic              anOutLbBank,
  output logic [5:0]        anOutLbAddr,
  output logic [DATA_W-1:0] anOutLbData,
  output logic              anOutUnderrun
);

  localparam logic [9:0] LAST_LINE = 10'(V_TOTAL - 1);
  localparam logic [9:0] VIS_LINES = 10'(V_DISPLAY);
  localparam logic [5:0] LAST_WORD = 6'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CLIENT} state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [9:0]          line_q, line_d;
  logic [5:0]          word_q, word_d;
  logic                discard_q, discard_d;
  logic                rr_q, rr_d;
  logic                gnt_q, gnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                lb_we_q, lb_we_d;
  logic                lb_bank_q, lb_bank_d;
  logic [5:0]          lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0]   lb_data_q, lb_data_d;
  logic                underrun_q, underrun_d;

  logic       trig, n_vis, mem_done, fetch_done, last_done, ur;
  logic       req0_eff, req1_eff, g;
  logic [9:0] n_line;

  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [9:0] line, input logic [5:0] word);
    logic [31:0] a;
    a = 32'(FB_BASE) + 32'(line) * 32'(WORDS_PER_LINE) + 32'(word);
    return a[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    line_d      = line_q;
    word_d      = word_q;
    discard_d   = discard_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    lb_we_d     = 1'b0;
    lb_bank_d   = lb_bank_q;
    lb_addr_d   = lb_addr_q;
    lb_data_d   = lb_data_q;
    underrun_d  = 1'b0;
    g           = 1'b0;

    trig       = (aX == 10'd0);
    n_line     = (aY == LAST_LINE) ? 10'd0 : aY + 10'd1;
    n_vis      = (n_line < VIS_LINES);
    mem_done   = mem_req_q && aMemReady;
    fetch_done = (state_q == FETCH) && mem_done;
    last_done  = fetch_done && !discard_q && (word_q == LAST_WORD);
    // A trigger that lands on the very cycle the last word completes is not an underrun.
    ur         = trig && pend_q && !last_done;
    // A client sees its ack this cycle and only drops its request next cycle.
    req0_eff   = aReq0 && !ack0_q;
    req1_eff   = aReq1 && !ack1_q;

    if (fetch_done) begin
      discard_d = 1'b0;
      if (!discard_q && !ur) begin
        lb_we_d   = 1'b1;
        lb_bank_d = line_q[0];
        lb_addr_d = word_q;
        lb_data_d = aMemRData;
        if (word_q == LAST_WORD) pend_d = 1'b0;
        else                     word_d = word_q + 6'd1;
      end
    end

    if (trig) begin
      underrun_d = ur;
      pend_d     = n_vis;
      word_d     = 6'd0;
      if (n_vis) line_d = n_line;
      // The in-flight read belongs to the abandoned line; let it finish and drop its data.
      if (ur && (state_q == FETCH) && mem_req_q && !aMemReady) discard_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_d) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = fetch_addr(line_d, word_d);
        end else if (req0_eff || req1_eff) begin
          g           = (req0_eff && req1_eff) ? ~rr_q : req1_eff;
          gnt_d       = g;
          state_d     = CLIENT;
          mem_req_d   = 1'b1;
          mem_we_d    = g ? aWe1 : aWe0;
          mem_addr_d  = g ? aAddr1 : aAddr0;
          mem_wdata_d = g ? aWData1 : aWData0;
        end
      end
      FETCH: begin
        if (mem_done) begin
          if (pend_d) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = fetch_addr(line_d, word_d);
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      CLIENT: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          rr_d      = gnt_q;
          rdata_d   = aMemRData;
          ack0_d    = !gnt_q;
          ack1_d    = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aClock) begin
    if (aReset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      line_q      <= '0;
      word_q      <= '0;
      discard_q   <= 1'b0;
      rr_q        <= 1'b1;
      gnt_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      lb_we_q     <= 1'b0;
      lb_bank_q   <= 1'b0;
      lb_addr_q   <= '0;
      lb_data_q   <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      line_q      <= line_d;
      word_q      <= word_d;
      discard_q   <= discard_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      lb_we_q     <= lb_we_d;
      lb_bank_q   <= lb_bank_d;
      lb_addr_q   <= lb_addr_d;
      lb_data_q   <= lb_data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign anOutAck0     = ack0_q;
  assign anOutAck1     = ack1_q;
  assign anOutRData    = rdata_q;
  assign anOutMemReq   = mem_req_q;
  assign anOutMemWe    = mem_we_q;
  assign anOutMemAddr  = mem_addr_q;
  assign anOutMemWData = mem_wdata_q;
  assign anOutLbWe     = lb_we_q;
  assign anOutLbBank   = lb_bank_q;
  assign anOutLbAddr   = lb_addr_q;
  assign anOutLbData   = lb_data_q;
  assign anOutUnderrun = underrun_q;

endmodule

// File: tb/tb_scanline_fetch_arbiter.sv
// Directed bench for scanline_fetch_arbiter: trigger vector table plus hand-written
// sequences for client arbitration, non-preemption, underrun and mid-fetch reset.
module tb_scanline_fetch_arbiter;

  logic        aClock = 1'b0;
  logic        aReset = 1'b1;
  logic [9:0]  aX = 10'd100, aY = 10'd0;
  logic        aReq0 = 1'b0, aReq1 = 1'b0, aWe0 = 1'b0, aWe1 = 1'b0;
  logic [17:0] aAddr0 = '0, aAddr1 = '0;
  logic [15:0] aWData0 = '0, aWData1 = '0;
  logic        anOutAck0, anOutAck1, anOutMemReq, anOutMemWe, anOutLbWe, anOutLbBank, anOutUnderrun;
  logic [15:0] anOutRData, anOutMemWData, anOutLbData, aMemRData;
  logic [17:0] anOutMemAddr;
  logic [5:0]  anOutLbAddr;
  logic        aMemReady;

  always #5 aClock = ~aClock;

  scanline_fetch_arbiter dut (
    .aClock(aClock), .aReset(aReset), .aX(aX), .aY(aY),
    .aReq0(aReq0), .aReq1(aReq1), .aWe0(aWe0), .aWe1(aWe1),
    .aAddr0(aAddr0), .aAddr1(aAddr1), .aWData0(aWData0), .aWData1(aWData1),
    .anOutAck0(anOutAck0), .anOutAck1(anOutAck1), .anOutRData(anOutRData),
    .anOutMemReq(anOutMemReq), .anOutMemWe(anOutMemWe), .anOutMemAddr(anOutMemAddr),
    .anOutMemWData(anOutMemWData), .aMemReady(aMemReady), .aMemRData(aMemRData),
    .anOutLbWe(anOutLbWe), .anOutLbBank(anOutLbBank), .anOutLbAddr(anOutLbAddr),
    .anOutLbData(anOutLbData), .anOutUnderrun(anOutUnderrun)
  );

  // Memory model: unwritten words read back a fixed address pattern.
  function automatic logic [15:0] pattern(input int a);
    return 16'(((a % 1024) * 7) + 16'h1234);
  endfunction

  logic [15:0] wmem [1024];
  bit          wvalid [1024];
  int          lat = 0;
  bit          hold_low = 1'b0;
  int          cnt = 0;
  int          cyc = 0;

  assign aMemReady = anOutMemReq && !hold_low && (cnt >= lat);
  assign aMemRData = wvalid[anOutMemAddr[9:0]] ? wmem[anOutMemAddr[9:0]] : pattern(int'(anOutMemAddr[9:0]));

  typedef struct { logic bank; logic [5:0] addr; logic [15:0] data; int cyc; } lb_ev_t;
  lb_ev_t lb_q[$];
  int     txn_q[$];
  int     ur_cnt = 0;
  int     viol = 0;
  logic   req_before = 1'b0, rdy_before = 1'b0, rst_at_edge = 1'b1;

  always @(posedge aClock) begin
    cyc         <= cyc + 1;
    cnt         <= (anOutMemReq && !aMemReady) ? cnt + 1 : 0;
    req_before  <= anOutMemReq;
    rdy_before  <= aMemReady;
    rst_at_edge <= aReset;
    if (anOutMemReq && aMemReady) begin
      txn_q.push_back(int'(anOutMemAddr));
      if (anOutMemWe) begin
        wmem[anOutMemAddr[9:0]]   <= anOutMemWData;
        wvalid[anOutMemAddr[9:0]] <= 1'b1;
      end
    end
  end

  always @(negedge aClock) begin
    if (anOutLbWe) lb_q.push_back('{anOutLbBank, anOutLbAddr, anOutLbData, cyc});
    if (anOutUnderrun) ur_cnt <= ur_cnt + 1;
    if (req_before && !rdy_before && !rst_at_edge && !anOutMemReq) viol <= viol + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic trigger(input logic [9:0] y);
    @(negedge aClock);
    aY = y;
    aX = 10'd0;
    @(negedge aClock);
    aX = 10'd100;
  endtask

  // Verify a complete captured line fetch against the memory pattern.
  task automatic check_line(input string name, input int line);
    int bad;
    bad = 0;
    chk({name, "_words"}, lb_q.size(), 40);
    if (lb_q.size() == 40) begin
      for (int i = 0; i < 40; i++) begin
        if (lb_q[i].addr !== 6'(i) || lb_q[i].bank !== 1'(line & 1) ||
            lb_q[i].data !== pattern(line * 40 + i)) bad++;
      end
      chk({name, "_w0_data"}, int'(lb_q[0].data), int'(pattern(line * 40)));
      chk({name, "_w39_addr"}, int'(lb_q[39].addr), 39);
    end
    chk({name, "_bad_entries"}, bad, 0);
  endtask

  task automatic client_do(input int id, input logic we, input logic [17:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output int ack_cyc);
    bit got;
    got = 1'b0;
    rd = '0;
    ack_cyc = -1;
    if (id == 0) begin aReq0 = 1'b1; aWe0 = we; aAddr0 = addr; aWData0 = wd; end
    else         begin aReq1 = 1'b1; aWe1 = we; aAddr1 = addr; aWData1 = wd; end
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge aClock);
      if ((id == 0 && anOutAck0) || (id == 1 && anOutAck1)) begin
        got = 1'b1;
        rd = anOutRData;
        ack_cyc = cyc;
      end
    end
    if (id == 0) aReq0 = 1'b0; else aReq1 = 1'b0;
    chk($sformatf("client%0d_ack_seen", id), int'(got), 1);
  endtask

  typedef struct { logic [9:0] y; int nwords; int line; } vec_t;
  vec_t vecs[6];

  initial begin
    logic [15:0] rd;
    int          ack_c, ur0, nsnap, bad;
    int          seq[$];

    vecs[0] = '{10'd10,  40, 11};
    vecs[1] = '{10'd524, 40, 0};
    vecs[2] = '{10'd479, 0,  0};
    vecs[3] = '{10'd0,   40, 1};
    vecs[4] = '{10'd478, 40, 479};
    vecs[5] = '{10'd500, 0,  0};

    // Reset state
    repeat (3) @(negedge aClock);
    chk("rst_memreq", int'(anOutMemReq), 0);
    chk("rst_lbwe", int'(anOutLbWe), 0);
    chk("rst_acks", int'({anOutAck0, anOutAck1}), 0);
    chk("rst_underrun", int'(anOutUnderrun), 0);
    chk("rst_memaddr", int'(anOutMemAddr), 0);
    aReset = 1'b0;
    repeat (2) @(negedge aClock);

    // Trigger table, memory always ready
    for (int v = 0; v < 6; v++) begin
      lb_q.delete();
      txn_q.delete();
      trigger(vecs[v].y);
      repeat (90) @(negedge aClock);
      if (vecs[v].nwords > 0) begin
        check_line($sformatf("vec%0d", v), vecs[v].line);
        chk($sformatf("vec%0d_first_memaddr", v), (txn_q.size() > 0) ? txn_q[0] : -1, vecs[v].line * 40);
      end else begin
        chk($sformatf("vec%0d_no_words", v), lb_q.size(), 0);
        chk($sformatf("vec%0d_no_txn", v), txn_q.size(), 0);
      end
    end
    chk("table_no_underrun", ur_cnt, 0);

    // Both clients requesting continuously: grants alternate starting with client 0
    aWe0 = 1'b0; aAddr0 = 18'd1002; aWe1 = 1'b0; aAddr1 = 18'd1003;
    aReq0 = 1'b1; aReq1 = 1'b1;
    bad = 0;
    for (int k = 0; k < 80 && seq.size() < 5; k++) begin
      @(negedge aClock);
      if (anOutAck0) begin seq.push_back(0); if (anOutRData !== pattern(1002)) bad++; end
      if (anOutAck1) begin seq.push_back(1); if (anOutRData !== pattern(1003)) bad++; end
      if (seq.size() == 4) aReq1 = 1'b0;
    end
    aReq0 = 1'b0; aReq1 = 1'b0;
    chk("rr_ack_count", seq.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_ack%0d", i), (seq.size() > i) ? seq[i] : -1, i % 2);
    chk("rr_rdata_bad", bad, 0);
    repeat (3) @(negedge aClock);

    // Write then read back through opposite clients
    client_do(0, 1'b1, 18'd1000, 16'hBEEF, rd, ack_c);
    client_do(1, 1'b0, 18'd1000, 16'h0000, rd, ack_c);
    chk("wr0_rd1_data", int'(rd), 16'hBEEF);
    client_do(1, 1'b1, 18'd1001, 16'h1357, rd, ack_c);
    client_do(0, 1'b0, 18'd1001, 16'h0000, rd, ack_c);
    chk("wr1_rd0_data", int'(rd), 16'h1357);

    // Client read in flight with slow memory when the line trigger arrives
    lat = 5;
    lb_q.delete();
    fork
      client_do(0, 1'b0, 18'd1004, 16'h0000, rd, ack_c);
      begin repeat (2) @(negedge aClock); trigger(10'd10); end
    join
    repeat (320) @(negedge aClock);
    chk("inflight_rdata", int'(rd), int'(pattern(1004)));
    chk("inflight_ack_before_fetch", int'((lb_q.size() > 0) && (lb_q[0].cyc > ack_c)), 1);
    check_line("inflight", 11);
    lat = 0;

    // Memory stalled across two triggers: one underrun, restart on the newer line
    lb_q.delete();
    txn_q.delete();
    ur0 = ur_cnt;
    hold_low = 1'b1;
    trigger(10'd10);
    repeat (5) @(negedge aClock);
    trigger(10'd11);
    repeat (5) @(negedge aClock);
    hold_low = 1'b0;
    repeat (90) @(negedge aClock);
    chk("underrun_pulses", ur_cnt - ur0, 1);
    chk("underrun_discarded_addr", (txn_q.size() > 0) ? txn_q[0] : -1, 440);
    chk("underrun_restart_addr", (txn_q.size() > 1) ? txn_q[1] : -1, 480);
    check_line("underrun", 12);

    // Reset in the middle of a fetch
    lb_q.delete();
    trigger(10'd20);
    repeat (10) @(negedge aClock);
    aReset = 1'b1;
    @(negedge aClock);
    chk("midrst_memreq", int'(anOutMemReq), 0);
    chk("midrst_lbwe", int'(anOutLbWe), 0);
    chk("midrst_acks", int'({anOutAck0, anOutAck1}), 0);
    @(negedge aClock);
    aReset = 1'b0;
    nsnap = lb_q.size();
    repeat (30) @(negedge aClock);
    chk("midrst_no_resume", lb_q.size(), nsnap);
    chk("midrst_idle_memreq", int'(anOutMemReq), 0);
    lb_q.delete();
    trigger(10'd10);
    repeat (90) @(negedge aClock);
    check_line("after_rst", 11);

    chk("memreq_early_drops", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
